// File: rtl/epsm_bus_bridge.sv
// -----------------------------------------------------------------------------
// epsm_bus_bridge
//
// Cartridge-side responder for the EPSM expansion-port write protocol. Each
// NES CPU write to $401C-$401F (exp_wr_n low during an M2-high phase) is
// captured once, queued in a small FIFO and replayed to the YM2608 with the
// chip's setup / strobe / hold / recovery timing.
//
// Ports
//   clk         module clock (50 MHz nominal)
//   rst         synchronous reset, active low
//   exp_wr_n    expansion write strobe, async, low = register write
//   exp_a       {A1,A0} from the expansion port, async
//   exp_m2      NES M2, async
//   exp_d       NES CPU data bus, async
//   opn_cs_n    OPNA chip select, active low
//   opn_wr_n    OPNA write strobe, active low
//   opn_a       OPNA {A1,A0}
//   opn_d       OPNA data
//   opn_d_oe    data-bus output enable toward the OPNA
//   fifo_level  occupied FIFO entries
//   busy        FIFO non-empty or replay in progress
//   ovf         sticky overflow flag
//   ovf_clr     synchronous clear of ovf (a simultaneous overflow wins)
// -----------------------------------------------------------------------------
module epsm_bus_bridge #(
   parameter int DEPTH_LOG2 = 4,
   parameter int SETUP_CYC  = 2,
   parameter int WR_CYC     = 4,
   parameter int HOLD_CYC   = 2,
   parameter int ADDR_WAIT  = 20,
   parameter int DATA_WAIT  = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exp_wr_n,
   input  logic [1:0]            exp_a,
   input  logic                  exp_m2,
   input  logic [7:0]            exp_d,
   output logic                  opn_cs_n,
   output logic                  opn_wr_n,
   output logic [1:0]            opn_a,
   output logic [7:0]            opn_d,
   output logic                  opn_d_oe,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  busy,
   output logic                  ovf,
   input  logic                  ovf_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_STROBE  = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_RECOVER = 3'd4;

   // ---- input synchronizers ----
   logic [1:0] m2_sync_q;
   logic [1:0] wr_sync_q;
   logic       m2_dly_q;
   logic [9:0] ad_s1_q, ad_s2_q;
   logic       m2_s, wr_s, m2_fall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         m2_sync_q <= 2'b00;
         wr_sync_q <= 2'b11;
         m2_dly_q  <= 1'b0;
      end else begin
         m2_sync_q <= {m2_sync_q[0], exp_m2};
         wr_sync_q <= {wr_sync_q[0], exp_wr_n};
         m2_dly_q  <= m2_sync_q[1];
      end
   end

   // Address/data take the same two-flop delay so they line up with wr_s.
   always_ff @(posedge clk) begin
      ad_s1_q <= {exp_a, exp_d};
      ad_s2_q <= ad_s1_q;
   end

   assign m2_s    = m2_sync_q[1];
   assign wr_s    = wr_sync_q[1];
   assign m2_fall = m2_dly_q & ~m2_s;

   // ---- capture latch ----
   // Re-captured every cycle the strobe is seen, so one M2 phase gives one
   // entry carrying the latest sample; committed on the following M2 fall.
   logic       cap_valid_q;
   logic [9:0] cap_q;
   logic       cap_hit, push_req;

   assign cap_hit  = m2_s & ~wr_s;
   assign push_req = m2_fall & cap_valid_q;

   always_ff @(posedge clk) begin
      if (!rst)         cap_valid_q <= 1'b0;
      else if (cap_hit) cap_valid_q <= 1'b1;
      else if (m2_fall) cap_valid_q <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (cap_hit) cap_q <= ad_s2_q;
   end

   // ---- FIFO ----
   logic [9:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2:0]   wp_q, rp_q, level;
   logic                  full, empty, push, pop;
   logic [2:0]            state_q, state_d;

   assign level = wp_q - rp_q;
   assign full  = level[DEPTH_LOG2];
   assign empty = (level == '0);
   assign push  = push_req & ~full;
   assign pop   = (state_q == S_IDLE) & ~empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp_q <= '0;
         rp_q <= '0;
         ovf  <= 1'b0;
      end else begin
         if (push) wp_q <= wp_q + 1'b1;
         if (pop)  rp_q <= rp_q + 1'b1;
         if (push_req && full) ovf <= 1'b1;
         else if (ovf_clr)     ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q[DEPTH_LOG2-1:0]] <= cap_q;
   end

   // ---- replay FSM with registered OPNA outputs ----
   logic [15:0] cnt_q, cnt_d;
   logic        cs_q, cs_d, wr_q, wr_d, oe_q, oe_d;
   logic [9:0]  ad_q, ad_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cs_d    = cs_q;
      wr_d    = wr_q;
      oe_d    = oe_q;
      ad_d    = ad_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_SETUP;
               ad_d    = mem_q[rp_q[DEPTH_LOG2-1:0]];
               cs_d    = 1'b0;
               oe_d    = 1'b1;
               cnt_d   = 16'(SETUP_CYC - 1);
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_STROBE;
               wr_d    = 1'b0;
               cnt_d   = 16'(WR_CYC - 1);
            end else cnt_d = cnt_q - 16'd1;
         end
         S_STROBE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               wr_d    = 1'b1;
               cnt_d   = 16'(HOLD_CYC - 1);
            end else cnt_d = cnt_q - 16'd1;
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_RECOVER;
               cs_d    = 1'b1;
               oe_d    = 1'b0;
               // ad_q[8] is the A0 of the write just completed
               cnt_d   = ad_q[8] ? 16'(DATA_WAIT - 1) : 16'(ADDR_WAIT - 1);
            end else cnt_d = cnt_q - 16'd1;
         end
         S_RECOVER: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 16'd1;
         end
         default: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            oe_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cs_q    <= 1'b1;
         wr_q    <= 1'b1;
         oe_q    <= 1'b0;
         ad_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         oe_q    <= oe_d;
         ad_q    <= ad_d;
      end
   end

   assign opn_cs_n   = cs_q;
   assign opn_wr_n   = wr_q;
   assign opn_d_oe   = oe_q;
   assign opn_a      = ad_q[9:8];
   assign opn_d      = ad_q[7:0];
   assign fifo_level = level;
   assign busy       = ~empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_epsm_bus_bridge.sv
module tb_epsm_bus_bridge;

   localparam int DEPTH_LOG2 = 4;
   localparam int SETUP_CYC  = 2;
   localparam int WR_CYC     = 4;
   localparam int HOLD_CYC   = 2;
   localparam int ADDR_WAIT  = 20;
   localparam int DATA_WAIT  = 100;
   localparam int OVF_N      = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                exp_wr_n, exp_m2, ovf_clr;
   logic [1:0]          exp_a;
   logic [7:0]          exp_d;
   logic                opn_cs_n, opn_wr_n, opn_d_oe, busy, ovf;
   logic [1:0]          opn_a;
   logic [7:0]          opn_d;
   logic [DEPTH_LOG2:0] fifo_level;

   epsm_bus_bridge #(
      .DEPTH_LOG2(DEPTH_LOG2), .SETUP_CYC(SETUP_CYC), .WR_CYC(WR_CYC),
      .HOLD_CYC(HOLD_CYC), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)
   ) dut (
      .clk(clk), .rst(rst), .exp_wr_n(exp_wr_n), .exp_a(exp_a), .exp_m2(exp_m2),
      .exp_d(exp_d), .opn_cs_n(opn_cs_n), .opn_wr_n(opn_wr_n), .opn_a(opn_a),
      .opn_d(opn_d), .opn_d_oe(opn_d_oe), .fifo_level(fifo_level), .busy(busy),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #10 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: every strobed NES write becomes one OPNA write, in order.
   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];

   // OPNA-side observer: collects replayed writes and checks bus timing.
   int   cyc = 0;
   int   cs_fall_c = 0, cs_rise_c = 0, wr_fall_c = 0, wr_rise_c = 0;
   int   prev_wait = 0, cs_falls = 0, m2f_cyc = 0;
   bit   have_prev = 0;
   logic prev_wr = 1'b1, prev_cs = 1'b1;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         prev_wr   = 1'b1;
         prev_cs   = 1'b1;
         have_prev = 0;
      end else begin
         if (prev_cs && !opn_cs_n) begin
            cs_falls++;
            if (have_prev) chk("recover", 32'((cyc - cs_rise_c) >= prev_wait), 32'd1);
            cs_fall_c = cyc;
         end
         if (!opn_wr_n) chk("wr_qual", {30'd0, opn_cs_n, opn_d_oe}, 32'd1);
         if (prev_wr && !opn_wr_n) begin
            chk("setup", 32'(cyc - cs_fall_c), 32'(SETUP_CYC));
            got_q.push_back({opn_a, opn_d});
            wr_fall_c = cyc;
         end
         if (!prev_wr && opn_wr_n) begin
            chk("wr_width", 32'(cyc - wr_fall_c), 32'(WR_CYC));
            wr_rise_c = cyc;
         end
         if (!prev_cs && opn_cs_n) begin
            chk("hold", 32'(cyc - wr_rise_c), 32'(HOLD_CYC));
            cs_rise_c = cyc;
            prev_wait = opn_a[0] ? DATA_WAIT : ADDR_WAIT;
            have_prev = 1;
         end
         prev_wr = opn_wr_n;
         prev_cs = opn_cs_n;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   // One NES bus cycle: M2 high ~360 ns then low ~220 ns.
   // mode 0: no strobe (data toggles), 1: strobe inside M2-high, 2: strobe
   // low across the whole M2-high phase, overlapping both edges.
   task automatic nes_cycle(input logic [1:0] a, input logic [7:0] d, input int mode);
      exp_a = a;
      exp_d = d;
      if (mode == 2) exp_wr_n = 1'b0;
      step(1);
      exp_m2 = 1'b1;
      step(3);
      if (mode == 1) exp_wr_n = 1'b0;
      if (mode == 0) exp_d = 8'($urandom);
      step(10);
      if (mode == 1) exp_wr_n = 1'b1;
      if (mode == 0) exp_a = 2'($urandom);
      step(5);
      exp_m2  = 1'b0;
      m2f_cyc = cyc;
      step(1);
      if (mode == 2) exp_wr_n = 1'b1;
      step(9);
      if (mode != 0) exp_q.push_back({a, d});
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      @(negedge clk); #1;
      while (busy && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_timeout", 32'(n < limit), 32'd1);
   endtask

   task automatic compare_q(input string tag);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_entry"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int   f0, n;
      logic [7:0] cur, prv;
      rst = 1'b0; exp_wr_n = 1'b1; exp_m2 = 1'b0; exp_a = 2'b00; exp_d = 8'h00;
      ovf_clr = 1'b0;
      step(5);
      @(negedge clk); #1;
      chk("rst_cs_n", 32'(opn_cs_n), 32'd1);
      chk("rst_wr_n", 32'(opn_wr_n), 32'd1);
      chk("rst_oe",   32'(opn_d_oe), 32'd0);
      chk("rst_a_d",  32'({opn_a, opn_d}), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf",  32'(ovf), 32'd0);
      step(1);
      rst = 1'b1;
      step(5);

      // single address write
      nes_cycle(2'b00, 8'h24, 1);
      chk("m2_to_cs", 32'((cs_fall_c > m2f_cyc) && (cs_fall_c - m2f_cyc <= 6)), 32'd1);
      wait_idle(500);
      chk("busy_tail", 32'(cyc - cs_rise_c), 32'(ADDR_WAIT));
      compare_q("single");

      // address + data pair
      nes_cycle(2'b00, 8'h27, 1);
      nes_cycle(2'b01, 8'h15, 1);
      wait_idle(1000);
      chk("data_recover", 32'(cyc - cs_rise_c), 32'(DATA_WAIT));
      compare_q("pair");

      // strobe-less M2 cycles
      f0 = cs_falls;
      for (int i = 0; i < 10; i++) nes_cycle(2'($urandom), 8'($urandom), 0);
      chk("nostb_level", 32'(fifo_level), 32'd0);
      chk("nostb_cs", 32'(cs_falls - f0), 32'd0);
      chk("nostb_busy", 32'(busy), 32'd0);
      compare_q("nostb");

      // long strobe
      nes_cycle(2'b10, 8'hA5, 2);
      wait_idle(500);
      compare_q("long");

      // randomized mix
      for (int i = 0; i < 14; i++)
         nes_cycle(2'($urandom), 8'($urandom), int'($urandom_range(0, 3)) % 3);
      wait_idle(4000);
      chk("rand_ovf", 32'(ovf), 32'd0);
      compare_q("rand");

      // overflow: data = index, A0=1 so replay is slow
      for (int i = 0; i < OVF_N; i++) nes_cycle(2'b01, 8'(i), 1);
      exp_q.delete();
      @(negedge clk); #1;
      chk("ovf_set", 32'(ovf), 32'd1);
      step(1);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      @(negedge clk); #1;
      chk("ovf_clr", 32'(ovf), 32'd0);
      wait_idle(8000);
      chk("ovf_dropped", 32'(got_q.size() < OVF_N && got_q.size() >= 16), 32'd1);
      prv = 8'h00;
      for (int i = 0; i < got_q.size(); i++) begin
         cur = got_q[i][7:0];
         if (i < 16) chk("ovf_head", 32'(cur), 32'(i));
         if (i > 0)  chk("ovf_order", 32'(cur > prv), 32'd1);
         prv = cur;
      end
      got_q.delete();

      // reset during STROBE with entries queued
      for (int i = 0; i < 5; i++) nes_cycle(2'b01, 8'(8'h40 + i), 1);
      n = 0;
      while (opn_wr_n && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      chk("rst_wait", 32'(n < 500), 32'd1);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("abort_wr_n", 32'(opn_wr_n), 32'd1);
      chk("abort_cs_n", 32'(opn_cs_n), 32'd1);
      chk("abort_oe",   32'(opn_d_oe), 32'd0);
      chk("abort_level", 32'(fifo_level), 32'd0);
      step(1);
      rst = 1'b1;
      got_q.delete();
      exp_q.delete();
      f0 = cs_falls;
      step(400);
      @(negedge clk); #1;
      chk("post_rst_cs", 32'(cs_falls - f0), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      compare_q("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
